// File: rtl/systolic_scheduler.sv
// Sequencer for a ROWS x COLS weight-stationary systolic array: weight load, row-staggered
// multiply wavefront, input-vector feed strobes and a one-cycle completion pulse.
module systolic_scheduler #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int STAGE_CYCLES = 4,
  parameter int VEC_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vectors,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic [ROWS-1:0]  load_weight,
  output logic [ROWS-1:0]  enable_mult,
  output logic             feed_valid,
  output logic             done
);

  // Compute time is tracked as (step, phase) with t = step*STAGE_CYCLES + phase, so the
  // largest step (N+ROWS+COLS-2) bounds the counter and covers the full T without wrap.
  localparam int STEP_MAX = (2**VEC_W - 1) + ROWS + COLS - 2;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
  localparam int PHASE_W  = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(STAGE_CYCLES - 1);
  localparam logic [STEP_W-1:0]  LOAD_LAST  = STEP_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic [STEP_W-1:0]  step, step_d;
  logic [PHASE_W-1:0] phase, phase_d;
  logic [VEC_W-1:0]   n_q, n_d;
  logic [STEP_W-1:0]  last_step;

  logic [ROWS-1:0]    load_weight_d;
  logic [ROWS-1:0]    enable_mult_d;
  logic               feed_valid_d;

  // Final wavefront step is N+ROWS+COLS-3; only consulted in COMPUTE, where N >= 1.
  assign last_step = STEP_W'(n_q) + STEP_W'(ROWS + COLS - 3);

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d = state;
    step_d  = step;
    phase_d = phase;
    n_d     = n_q;
    if (enable) begin
      if (abort) begin
        state_d = S_IDLE;
        step_d  = '0;
        phase_d = '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state_d = S_LOAD;
              step_d  = '0;
              phase_d = '0;
              n_d     = num_vectors;
            end
          end
          S_LOAD: begin
            if (step == LOAD_LAST) begin
              step_d  = '0;
              phase_d = '0;
              state_d = (n_q == '0) ? S_DONE : S_COMPUTE;
            end else begin
              step_d = step + 1'b1;
            end
          end
          S_COMPUTE: begin
            if (phase == PHASE_LAST) begin
              phase_d = '0;
              if (step == last_step) begin
                state_d = S_DONE;
                step_d  = '0;
              end else begin
                step_d = step + 1'b1;
              end
            end else begin
              phase_d = phase + 1'b1;
            end
          end
          S_DONE:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Strobes are decoded from the next state so they land in registers aligned with it.
  // enable_mult[r] spans steps [r, N+r+COLS-1), i.e. t in [r*S, (N+r+COLS-1)*S).
  always_comb begin
    load_weight_d = '0;
    enable_mult_d = '0;
    feed_valid_d  = 1'b0;
    if (state_d == S_LOAD) begin
      load_weight_d = ROWS'(1) << step_d;
    end
    if (state_d == S_COMPUTE) begin
      for (int r = 0; r < ROWS; r++) begin
        enable_mult_d[r] = (step_d >= STEP_W'(r)) &&
                           (step_d < STEP_W'(n_d) + STEP_W'(r + COLS - 1));
      end
      feed_valid_d = (phase_d == '0) && (step_d < STEP_W'(n_d));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      step        <= '0;
      phase       <= '0;
      n_q         <= '0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      load_weight <= '0;
      enable_mult <= '0;
      feed_valid  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      step        <= step_d;
      phase       <= phase_d;
      n_q         <= n_d;
      ready       <= (state_d == S_IDLE);
      busy        <= (state_d == S_LOAD) || (state_d == S_COMPUTE);
      load_weight <= load_weight_d;
      enable_mult <= enable_mult_d;
      feed_valid  <= feed_valid_d;
      done        <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Directed bench for systolic_scheduler: a 4x4 instance for most scenarios and a 2x2 instance
// for the small wavefront case, observed through a shared mux.
module tb_systolic_scheduler;

  logic       clk = 1'b0;
  logic       reset, enable, start, abort, sel;
  logic [7:0] num_vectors;

  logic       start_a, start_b;
  logic       ready_a, busy_a, feed_a, done_a;
  logic [3:0] lw_a, en_a;
  logic       ready_b, busy_b, feed_b, done_b;
  logic [1:0] lw_b, en_b;

  logic       obs_ready, obs_busy, obs_feed, obs_done;
  logic [3:0] obs_lw, obs_en;

  always #5 clk = ~clk;

  assign start_a   = start & ~sel;
  assign start_b   = start & sel;
  assign obs_ready = sel ? ready_b : ready_a;
  assign obs_busy  = sel ? busy_b : busy_a;
  assign obs_feed  = sel ? feed_b : feed_a;
  assign obs_done  = sel ? done_b : done_a;
  assign obs_lw    = sel ? {2'b00, lw_b} : lw_a;
  assign obs_en    = sel ? {2'b00, en_b} : en_a;

  systolic_scheduler #(.ROWS(4), .COLS(4), .STAGE_CYCLES(4), .VEC_W(8)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .start(start_a), .num_vectors(num_vectors),
    .abort(abort), .ready(ready_a), .busy(busy_a), .load_weight(lw_a), .enable_mult(en_a),
    .feed_valid(feed_a), .done(done_a));

  systolic_scheduler #(.ROWS(2), .COLS(2), .STAGE_CYCLES(4), .VEC_W(8)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .start(start_b), .num_vectors(num_vectors),
    .abort(abort), .ready(ready_b), .busy(busy_b), .load_weight(lw_b), .enable_mult(en_b),
    .feed_valid(feed_b), .done(done_b));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int n);
    num_vectors = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, int'(obs_ready), 1);
    check({tag, "_busy"},  int'(obs_busy), 0);
    check({tag, "_strobes"}, int'({obs_lw, obs_en, obs_feed, obs_done}), 0);
  endtask

  // Job statistics, in compute-time t = k - ROWS, where k counts enabled edges after accept.
  int rise[4], last[4], feed_t[8];
  int feed_cnt, done_cnt, done_k, done_wall, lw_err, frz_err, ready_after, busy_at_done;

  task automatic observe(input int rows, input int stall_k, input int stall_len, input int poke_k);
    int k, wall, t, exp_lw;
    logic [11:0] snap;
    for (int r = 0; r < 4; r++) begin
      rise[r] = -1;
      last[r] = -1;
    end
    for (int i = 0; i < 8; i++) feed_t[i] = -1;
    feed_cnt = 0; done_cnt = 0; done_k = -1; done_wall = -1;
    lw_err = 0; frz_err = 0; ready_after = -1; busy_at_done = -1;
    k = 0;
    wall = 0;
    while (k < 200) begin
      t = k - rows;
      exp_lw = (k < rows) ? (1 << k) : 0;
      if (int'(obs_lw) != exp_lw) lw_err++;
      for (int r = 0; r < 4; r++) begin
        if (obs_en[r]) begin
          if (rise[r] < 0) rise[r] = t;
          last[r] = t;
        end
      end
      if (obs_feed) begin
        if (feed_cnt < 8) feed_t[feed_cnt] = t;
        feed_cnt++;
      end
      if (obs_done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k       = k;
          done_wall    = wall;
          busy_at_done = int'(obs_busy);
        end
      end
      if (done_k >= 0 && k == done_k + 1) ready_after = int'(obs_ready);
      if (done_k >= 0 && k == done_k + 2) break;
      if (k == stall_k) begin
        snap   = {obs_ready, obs_busy, obs_lw, obs_en, obs_feed, obs_done};
        enable = 1'b0;
        repeat (stall_len) begin
          tick();
          wall++;
          if ({obs_ready, obs_busy, obs_lw, obs_en, obs_feed, obs_done} !== snap) frz_err++;
        end
        enable = 1'b1;
      end
      if (k == poke_k) start = 1'b1;
      tick();
      start = 1'b0;
      k++;
      wall++;
    end
  endtask

  initial begin
    int dones;
    reset = 1'b1; enable = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; num_vectors = '0;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    tick();

    // 2x2, N=2: T=16; row 0 multiplies t0-11, row 1 t4-15; feeds at t0, t4.
    sel = 1'b1;
    accept(2);
    observe(2, -1, 0, -1);
    check("t1_load_seq", lw_err, 0);
    check("t1_en0_rise", rise[0], 0);
    check("t1_en0_fall", last[0] + 1, 12);
    check("t1_en1_rise", rise[1], 4);
    check("t1_en1_fall", last[1] + 1, 16);
    check("t1_feed_cnt", feed_cnt, 2);
    check("t1_feed_t0", feed_t[0], 0);
    check("t1_feed_t1", feed_t[1], 4);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_t", done_k - 2, 16);
    check("t1_busy_at_done", busy_at_done, 0);
    check("t1_ready_after", ready_after, 1);
    sel = 1'b0;

    // 4x4, N=4: T=40; row 3 rises t12 falls t40; row 0 falls t28.
    accept(4);
    observe(4, -1, 0, -1);
    check("t2_load_seq", lw_err, 0);
    check("t2_en0_rise", rise[0], 0);
    check("t2_en0_fall", last[0] + 1, 28);
    check("t2_en3_rise", rise[3], 12);
    check("t2_en3_fall", last[3] + 1, 40);
    check("t2_feed_cnt", feed_cnt, 4);
    check("t2_feed_t3", feed_t[3], 12);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_t", done_k - 4, 40);
    check("t2_ready_after", ready_after, 1);

    // N=0: four load strobes, then done straight away.
    accept(0);
    observe(4, -1, 0, -1);
    check("t3_load_seq", lw_err, 0);
    check("t3_done_k", done_k, 4);
    check("t3_en_never", rise[0] + rise[1] + rise[2] + rise[3], -4);
    check("t3_feed_cnt", feed_cnt, 0);
    check("t3_done_cnt", done_cnt, 1);

    // enable low for 5 cycles at t=7: outputs frozen, done shifts by exactly 5 cycles.
    accept(4);
    observe(4, 11, 5, -1);
    check("t4_frozen", frz_err, 0);
    check("t4_done_k", done_k, 44);
    check("t4_done_wall", done_wall, 49);
    check("t4_en3_fall", last[3] + 1, 40);
    check("t4_feed_cnt", feed_cnt, 4);

    // abort at t=10, then a fresh start one cycle later runs normally.
    accept(4);
    repeat (14) tick();
    check("t5_busy_pre", int'(obs_busy), 1);
    check("t5_en0_pre", int'(obs_en[0]), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("t5_abort");
    accept(4);
    observe(4, -1, 0, -1);
    check("t5_restart_load", lw_err, 0);
    check("t5_restart_done_k", done_k, 44);
    check("t5_restart_done_cnt", done_cnt, 1);

    // start during LOAD and in the done cycle are both ignored.
    accept(4);
    observe(4, -1, 0, 3);
    check("t6_busy_start_load", lw_err, 0);
    check("t6_busy_start_done_k", done_k, 44);
    accept(4);
    observe(4, -1, 0, 44);
    check("t6_done_cycle_start_lw", lw_err, 0);
    check("t6_done_cycle_start_ready", ready_after, 1);

    // start+abort in IDLE: abort wins; abort alone in IDLE; start while enable is low.
    num_vectors = 8'd3;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle("t6_start_abort");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("t6_abort_idle");
    enable = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    tick();
    check_idle("t6_start_disabled");

    // reset at t=5 discards the job with no done pulse.
    accept(4);
    repeat (9) tick();
    check("t6_busy_pre_reset", int'(obs_busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("t6_reset");
    dones = 0;
    repeat (60) begin
      tick();
      if (obs_done) dones++;
    end
    check("t6_no_done_after_reset", dones, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
